// File: rtl/mips_mc_pkg.sv
// Shared encodings for the MIPS multicycle control FSM: states, opcodes,
// datapath mux selects and the control word driven by the output decoder.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       jal_flag;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: state (+ memory handshake) to datapath control word.
// mem_ready is tied high by the top level when wait states are disabled.
module mc_output_decode
    import mips_mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.ir_write  = mem_ready;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.pc_write  = mem_ready;
            end
            // Branch target is precomputed here so BRANCH only needs the compare.
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = PC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_src     = PC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.jal_flag   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and reset gating.
// Optional feature macro MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall until mem_ready.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       JALFlag,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;
    logic   rdy;

`ifdef MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state),
        .mem_ready (rdy),
        .ctrl      (ctrl)
    );

    // Outputs are gated while reset is held so an aborted instruction cannot write.
    assign ctrl_g     = rst_n ? ctrl : '0;
    assign illegal_op = rst_n && (state == S_DECODE) && !op_supported(opcode);

    assign PCWrite    = ctrl_g.pc_write;
    assign Branch     = ctrl_g.branch;
    assign IorD       = ctrl_g.iord;
    assign MemRead    = ctrl_g.mem_read;
    assign MemWrite   = ctrl_g.mem_write;
    assign IRWrite    = ctrl_g.ir_write;
    assign MemtoReg   = ctrl_g.mem_to_reg;
    assign RegDst     = ctrl_g.reg_dst;
    assign RegWrite   = ctrl_g.reg_write;
    assign JALFlag    = ctrl_g.jal_flag;
    assign ALUSrcA    = ctrl_g.alu_src_a;
    assign ALUSrcB    = ctrl_g.alu_src_b;
    assign ALUOp      = ctrl_g.alu_op;
    assign PCSrc      = ctrl_g.pc_src;
    assign instr_done = ctrl_g.instr_done;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It replaces per-instruction combinational decode with a state machine that sequences one shared ALU, one unified instruction/data memory and the register file across several clock cycles per instruction. The block sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables. It supports R-type, LW, SW, BEQ, ADDI, J and JAL.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: instruction register bits [31:26]; held stable by the datapath after FETCH.
- `mem_ready` in 1: memory-access completion. Used only when `MEM_WAIT_EN` is defined; ignored otherwise.
- `PCWrite` out 1: unconditional PC load.
- `Branch` out 1: conditional PC load; the datapath ANDs it with ALU zero.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` out 1: memory read enable.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write-data select; 0 = ALUOut, 1 = MDR.
- `RegDst` out 1: destination select; 0 = rt, 1 = rd.
- `RegWrite` out 1: register file write enable.
- `JALFlag` out 1: forces destination $31 and write data PC+4.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = A register.
- `ALUSrcB` out 2: ALU B select; 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = decode by funct.
- `PCSrc` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal_op` out 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Moore FSM with a 4-bit registered state. All outputs are decoded combinationally from the state, qualified by `mem_ready` where noted below. Any output not listed for a state is 0.
- **FETCH**
  - Outputs: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1.
  - Next state: DECODE.
- **DECODE**
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP; 000011 → JAL.
  - Any other opcode: illegal_op=1, next state FETCH; the PC has already advanced by 4.
- **MEMADR**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: LW → MEMRD, SW → MEMWR.
- **MEMRD**
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEMWB.
- **MEMWB**
  - Outputs: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- **MEMWR**
  - Outputs: MemWrite=1, IorD=1, instr_done=1.
  - Next state: FETCH.
- **EXEC**
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: ALUWB.
- **ALUWB**
  - Outputs: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1.
  - Next state: FETCH.
- **ADDIEX**
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: ADDIWB.
- **ADDIWB**
  - Outputs: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1.
  - Next state: FETCH.
- **JUMP**
  - Outputs: PCSrc=10, PCWrite=1, instr_done=1.
  - Next state: FETCH.
- **JAL**
  - Outputs: PCSrc=10, PCWrite=1, RegWrite=1, JALFlag=1, instr_done=1.
  - Next state: FETCH.
- Unused state encodings (13–15) → FETCH, with all outputs 0.

## Timing
- Reset:
  - `rst_n`=0 sampled at a rising edge loads state FETCH.
  - While `rst_n`=0, every output is forced to 0.
  - FETCH outputs appear in the same cycle `rst_n` returns to 1.
  - Reset asserted mid-instruction aborts it; no write enable is asserted during the reset cycle.
- Cycles per instruction (no wait states): LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, JAL 3, illegal opcode 2.
- `instr_done` is high for exactly one cycle per completed instruction. It never pulses for an illegal opcode.

## Configuration
- `MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold their state until `mem_ready`=1.
  - During the hold, MemRead/MemWrite and IorD stay asserted.
  - IRWrite, PCWrite and (in MEMWR) instr_done are asserted only in the cycle `mem_ready`=1.
  - MemWrite is asserted in every MEMWR cycle; the write commits in the `mem_ready`=1 cycle.
- `MEM_WAIT_EN` undefined: `mem_ready` is ignored and every memory state lasts one cycle.

## Structure
- Package `mips_mc_pkg` holds:
  - the state encoding constants;
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL);
  - the ALUOp, ALUSrcB and PCSrc encodings.
- Sub-module `mc_output_decode`: purely combinational, state (+ `mem_ready`) → control word. The top level keeps the state register and next-state logic.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles → all outputs 0; after release, cycle 0 shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- **LW:** opcode 100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in cycle 4; instr_done pulses once.
- **JAL:** opcode 000011 → cycle 2 shows PCWrite=1, PCSrc=10, RegWrite=1, JALFlag=1; next cycle is FETCH.
- **Illegal opcode:** opcode 111111 → illegal_op=1 in DECODE; FETCH on the next cycle; no RegWrite, no MemWrite, no instr_done.
- **Wait states (`MEM_WAIT_EN` defined):** SW with `mem_ready` held 0 for 3 cycles in MEMWR → MemWrite=1 for 4 cycles; instr_done only in the `mem_ready`=1 cycle; SW CPI = 7.
- **Reset mid-instruction:** assert `rst_n`=0 during EXEC → RegWrite is never asserted; FETCH follows the release.
